// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port memory between an
//   instruction-fetch port and a data (load/store) port.
// Latency: request sampled in IDLE at edge N -> mem access in cycle N+1 ->
//   ready pulse in cycle N+2; one access per 3 cycles.
// Backpressure: requesters hold req until their one-cycle ready pulse; requests
//   are only looked at while IDLE, so a waiting port simply keeps req high.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   i_req/i_addr               fetch request and byte address
//   i_rdata/i_ready            fetched word and completion pulse
//   d_req/d_we/d_addr/d_wdata  data request, store flag, address, store data
//   d_rdata/d_ready            load data and completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  shared memory port
//   busy                       arbiter is not IDLE
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  // instruction-fetch port
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  // data port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  // shared memory
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  // status
  output logic          busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ACC_I = 3'd1;
  localparam logic [2:0] RSP_I = 3'd2;
  localparam logic [2:0] ACC_D = 3'd3;
  localparam logic [2:0] RSP_D = 3'd4;

  logic [2:0]    state_q, state_d;
  // 1 = data port received the most recent grant
  logic          last_d_q, last_d_d;
  // access captured at grant time; request inputs are ignored afterwards
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  // last completed read per port
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic          grant_i;
  logic          grant_d;
  logic          in_acc;

  // Fetch wins when alone, or on a tie when data had the previous grant.
  always_comb begin
    grant_i = i_req && (!d_req || last_d_q);
    grant_d = d_req && !grant_i;
  end

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d  = ACC_I;
          last_d_d = 1'b0;
          addr_d   = i_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
        end else if (grant_d) begin
          state_d  = ACC_D;
          last_d_d = 1'b1;
          addr_d   = d_addr;
          we_d     = d_we;
          wdata_d  = d_wdata;
        end
      end
      ACC_I: state_d = RSP_I;
      ACC_D: state_d = RSP_D;
      RSP_I: begin
        state_d   = IDLE;
        i_rdata_d = mem_rdata;
      end
      RSP_D: begin
        state_d = IDLE;
        // a store completes without disturbing the last load result
        if (!we_q) begin
          d_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b1;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // All outputs decode from the state register, so reset forces them to zero
  // immediately without waiting for a clock.
  always_comb begin
    in_acc    = (state_q == ACC_I) || (state_q == ACC_D);
    mem_en    = in_acc;
    mem_we    = (state_q == ACC_D) && we_q;
    mem_addr  = in_acc ? addr_q : '0;
    mem_wdata = mem_we ? wdata_q : '0;
    i_ready   = (state_q == RSP_I);
    d_ready   = (state_q == RSP_D);
    // memory data arrives in the response cycle; pass it straight through so
    // it is valid alongside ready, then hold the registered copy
    i_rdata   = i_ready ? mem_rdata : i_rdata_q;
    d_rdata   = (d_ready && !we_q) ? mem_rdata : d_rdata_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a transaction-level
//   reference model (grant slots every 3 edges, round-robin ties, shadow memory).
// Directed scenarios first, then randomized requesters.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // memory seen by the DUT, and the model's independent shadow of it
  logic [31:0] dmem[256];
  logic [31:0] ref_mem[256];

  // reference model state
  int          edge_n;
  int          next_sample;
  int          acc_edge;
  bit          acc_d;
  bit          acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  bit          last_d;
  logic [31:0] exp_i_rdata;
  logic [31:0] exp_d_rdata;

  // observed ready pulses
  int rdy_edge[$];
  bit rdy_is_d[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  task automatic model_reset();
    acc_edge    = -10;
    acc_d       = 1'b0;
    acc_we      = 1'b0;
    acc_addr    = '0;
    acc_wdata   = '0;
    last_d      = 1'b1;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_i_rdata"},   i_rdata, 32'h0);
    check_val({tag, "_d_rdata"},   d_rdata, 32'h0);
    check_val({tag, "_i_ready"},   32'(i_ready), 32'h0);
    check_val({tag, "_d_ready"},   32'(d_ready), 32'h0);
    check_val({tag, "_mem_en"},    32'(mem_en), 32'h0);
    check_val({tag, "_mem_we"},    32'(mem_we), 32'h0);
    check_val({tag, "_mem_addr"},  mem_addr, 32'h0);
    check_val({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check_val({tag, "_busy"},      32'(busy), 32'h0);
  endtask

  // Compare every output against the model for the cycle following edge_n.
  task automatic check_cycle();
    bit in_acc;
    bit in_rsp;
    in_acc = (acc_edge == edge_n);
    in_rsp = (acc_edge + 1 == edge_n);
    if (in_rsp && !acc_d) exp_i_rdata = ref_mem[widx(acc_addr)];
    if (in_rsp && acc_d && !acc_we) exp_d_rdata = ref_mem[widx(acc_addr)];
    check_val("mem_en", 32'(mem_en), 32'(in_acc));
    check_val("mem_we", 32'(mem_we), 32'(in_acc && acc_we));
    if (in_acc) begin
      check_val("mem_addr", mem_addr, acc_addr);
      if (acc_we) check_val("mem_wdata", mem_wdata, acc_wdata);
    end
    check_val("i_ready", 32'(i_ready), 32'(in_rsp && !acc_d));
    check_val("d_ready", 32'(d_ready), 32'(in_rsp && acc_d));
    check_val("i_rdata", i_rdata, exp_i_rdata);
    check_val("d_rdata", d_rdata, exp_d_rdata);
    check_val("busy", 32'(busy), 32'(in_acc || in_rsp));
    if (i_ready) begin rdy_edge.push_back(edge_n); rdy_is_d.push_back(1'b0); end
    if (d_ready) begin rdy_edge.push_back(edge_n); rdy_is_d.push_back(1'b1); end
  endtask

  // Advance one clock: model decides the grant at this edge from the current
  // inputs, the bench memory responds, then outputs are checked.
  task automatic tick();
    logic        cur_en;
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    int          e;
    cur_en    = mem_en;
    cur_we    = mem_we;
    cur_addr  = mem_addr;
    cur_wdata = mem_wdata;
    e = edge_n + 1;
    if (acc_edge == edge_n && acc_we) ref_mem[widx(acc_addr)] = acc_wdata;
    if (e >= next_sample && (i_req || d_req)) begin
      // data wins if alone, or on a tie when fetch had the previous grant
      acc_d       = d_req && (!i_req || !last_d);
      acc_addr    = acc_d ? d_addr : i_addr;
      acc_we      = acc_d && d_we;
      acc_wdata   = d_wdata;
      acc_edge    = e;
      next_sample = e + 3;
      last_d      = acc_d;
    end
    @(posedge clk);
    edge_n = e;
    #1;
    if (cur_en) begin
      if (cur_we) dmem[widx(cur_addr)] = cur_wdata;
      else        mem_rdata = dmem[widx(cur_addr)];
    end
    #1;
    check_cycle();
  endtask

  initial begin
    int          e0;
    bit          found;
    bit          i_out;
    bit          d_out;
    logic [31:0] v;

    reset = 1'b1;
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0;
    edge_n = 0;
    next_sample = 0;
    model_reset();
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      dmem[i] = v;
      ref_mem[i] = v;
    end
    dmem[16] = 32'h8C100004;
    ref_mem[16] = 32'h8C100004;

    #1;
    check_reset_outputs("rst0");
    repeat (2) begin
      @(posedge clk);
      edge_n++;
    end
    #2;
    check_reset_outputs("rst1");
    reset = 1'b0;
    next_sample = edge_n + 1;

    // lone fetch
    i_req = 1; i_addr = 32'h40;
    tick();
    check_val("fetch_mem_en", 32'(mem_en), 32'h1);
    check_val("fetch_mem_addr", mem_addr, 32'h40);
    tick();
    check_val("fetch_ready", 32'(i_ready), 32'h1);
    check_val("fetch_rdata", i_rdata, 32'h8C100004);
    i_req = 0;
    tick();

    // store, then read it back
    d_req = 1; d_we = 1; d_addr = 32'h54; d_wdata = 32'h0000ABCD;
    tick();
    check_val("st_mem_en", 32'(mem_en), 32'h1);
    check_val("st_mem_we", 32'(mem_we), 32'h1);
    check_val("st_mem_addr", mem_addr, 32'h54);
    check_val("st_mem_wdata", mem_wdata, 32'h0000ABCD);
    tick();
    check_val("st_ready", 32'(d_ready), 32'h1);
    check_val("st_d_rdata_kept", d_rdata, 32'h0);
    d_req = 0;
    tick();
    d_req = 1; d_we = 0;
    tick();
    tick();
    check_val("ld_back", d_rdata, 32'h0000ABCD);
    d_req = 0;
    tick();

    // inputs change and req drops during ACC_D
    d_req = 1; d_we = 0; d_addr = 32'h10;
    tick();
    d_addr = 32'h20; d_req = 0;
    #1;
    check_val("chg_mem_addr", mem_addr, 32'h10);
    tick();
    check_val("chg_ready", 32'(d_ready), 32'h1);
    tick();

    // reset during ACC_I, then tie with both requests held
    i_req = 1; i_addr = 32'h100;
    d_req = 1; d_we = 0; d_addr = 32'h104;
    found = 0;
    for (int k = 0; k < 6 && !found; k++) begin
      tick();
      if (acc_edge == edge_n && !acc_d) found = 1;
    end
    check_val("reach_acc_i", 32'(found), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_acc");
    @(posedge clk);
    edge_n++;
    #2;
    check_reset_outputs("rst_hold");
    model_reset();
    reset = 1'b0;
    next_sample = edge_n + 1;
    e0 = edge_n + 1;
    rdy_edge.delete();
    rdy_is_d.delete();
    for (int k = 0; k < 12; k++) begin
      tick();
      i_req = !i_ready;
      d_req = !d_ready;
    end
    check_val("tie_count", 32'(rdy_edge.size()), 32'd4);
    for (int j = 0; j < 4; j++) begin
      check_val($sformatf("tie%0d_cycle", j), 32'(rdy_edge[j] - e0 + 1), 32'(2 + 3 * j));
      check_val($sformatf("tie%0d_port", j), 32'(rdy_is_d[j]), 32'(j % 2));
    end
    i_req = 0; d_req = 0;
    tick();
    tick();

    // randomized requesters
    i_out = 0;
    d_out = 0;
    for (int c = 0; c < 1500; c++) begin
      if (i_ready) begin
        i_out = 0; i_req = 0;
      end else if (!i_out) begin
        if ($urandom_range(0, 2) == 0) begin
          i_out = 1; i_req = 1; i_addr = $urandom & 32'hFFFF_FFFC;
        end
      end else if (acc_edge == edge_n && !acc_d && $urandom_range(0, 1) == 1) begin
        i_addr = $urandom;
        if ($urandom_range(0, 3) == 0) i_req = 0;
      end
      if (d_ready) begin
        d_out = 0; d_req = 0;
      end else if (!d_out) begin
        if ($urandom_range(0, 2) == 0) begin
          d_out = 1; d_req = 1; d_we = 1'($urandom_range(0, 1));
          d_addr = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom;
        end
      end else if (acc_edge == edge_n && acc_d && $urandom_range(0, 1) == 1) begin
        d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) d_req = 0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: AW, default 32, address width.
REQ-002 Parameter: DW, default 32, data width.
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high.
REQ-005 Port: i_req  input  1  instruction-fetch read request; held until i_ready.
REQ-006 Port: i_addr  input  AW  instruction-fetch byte address.
REQ-007 Port: i_rdata  output  DW  fetched word; valid while i_ready=1.
REQ-008 Port: i_ready  output  1  one-cycle completion pulse for the instruction port.
REQ-009 Port: d_req  input  1  data-access request; held until d_ready.
REQ-010 Port: d_we  input  1  1=store, 0=load.
REQ-011 Port: d_addr  input  AW  data byte address.
REQ-012 Port: d_wdata  input  DW  store data.
REQ-013 Port: d_rdata  output  DW  load data; valid while d_ready=1 after a load.
REQ-014 Port: d_ready  output  1  one-cycle completion pulse for the data port.
REQ-015 Port: mem_en  output  1  shared single-port memory access strobe.
REQ-016 Port: mem_we  output  1  shared memory write enable; only ever 1 when mem_en=1.
REQ-017 Port: mem_addr  output  AW  shared memory address.
REQ-018 Port: mem_wdata  output  DW  shared memory write data.
REQ-019 Port: mem_rdata  input  DW  shared memory read data; valid the cycle after mem_en.
REQ-020 Port: busy  output  1  1 whenever state is not IDLE.

Function
REQ-021 The FSM SHALL have five states: IDLE, ACC_I, RSP_I, ACC_D, RSP_D.
REQ-022 In IDLE, the FSM samples i_req and d_req; with neither asserted it stays in IDLE.
REQ-023 In IDLE, with exactly one request asserted, the FSM goes to ACC_I or ACC_D respectively.
REQ-024 With both requests asserted in IDLE, the FSM grants the port NOT recorded in last_grant (round-robin); last_grant updates on every grant.
REQ-025 On grant, the FSM latches the granted port's addr, and for data also we and wdata, into internal registers; later changes on request inputs do not affect the access.
REQ-026 In ACC_x: mem_en=1, mem_addr=latched addr; for a data store mem_we=1 and mem_wdata=latched wdata; otherwise mem_we=0.
REQ-027 ACC_x goes unconditionally to RSP_x.
REQ-028 In RSP_x: ready_x=1 for exactly this cycle, mem_en=0.
REQ-029 In RSP_x for a read, rdata_x is registered from mem_rdata and held until the next read completion on that port.
REQ-030 A store leaves d_rdata unchanged.
REQ-031 RSP_x goes unconditionally to IDLE.
REQ-032 Latency: a request first sampled in IDLE at edge N gives ready at cycle N+2; throughput is one access per 3 cycles.
REQ-033 Requests sampled in RSP_x are ignored; the requester drops req the cycle after ready, and the arbiter re-evaluates only in IDLE.
REQ-034 Deassertion of req during ACC_x or RSP_x does not abort the access; ready still pulses.
REQ-035 Starvation bound: with both ports continuously requesting, grants SHALL strictly alternate I,D,I,D.
REQ-036 i_ready and d_ready are never 1 in the same cycle; mem_en is never 1 in RSP or IDLE.

Reset
REQ-037 While reset=1, independent of clk: state=IDLE, last_grant=D (so I wins the first tie), and all latched registers=0.
REQ-038 While reset=1, all outputs=0: i_rdata, d_rdata, i_ready, d_ready, mem_en, mem_we, mem_addr, mem_wdata, busy.
REQ-039 Reset asserted mid-access (ACC_x or RSP_x) abandons the access: no ready pulse; a write in ACC_D may be lost.
REQ-040 After reset deassertion, the first IDLE sampling occurs at the next rising edge.

Verification
REQ-041 Lone fetch: i_req=1, i_addr=0x00000040 at edge N, mem_rdata=0x8C100004 in ACC_I -> mem_en=1 and addr=0x40 in cycle N+1; i_ready=1 and i_rdata=0x8C100004 in N+2.
REQ-042 Store: d_req=1, d_we=1, d_addr=0x54, d_wdata=0x0000ABCD -> one cycle with mem_en=1, mem_we=1, mem_addr=0x54, mem_wdata=0xABCD; then d_ready=1 with d_rdata unchanged.
REQ-043 Tie after reset: i_req and d_req both held -> grant order I,D,I,D; ready pulses at cycles 2,5,8,11 after the first sampling edge.
REQ-044 Input change mid-access: d_addr changes from 0x10 to 0x20 during ACC_D -> mem_addr stays 0x10.
REQ-045 Reset in ACC_I: assert reset -> same cycle all outputs=0, no i_ready; after release with both requests held, I is granted first.
